arm_seq_shifter: RTL and testbench
==================================

Name: arm_seq_shifter

Overview:
- Multi-cycle, parametrised ARM barrel-shift unit for the data-processing operand-2 path.
- Successor to the combinational single-bit-loop shifter.
- Adds clocked operation, start/done handshake, configurable bits-per-cycle and full ARM shift semantics: immediate vs register forms, RRX, amounts ≥ WIDTH, carry-in passthrough.
- Sits between the register-file read stage and the ALU; the ALU waits on done.

Parameters:
- WIDTH, 32: data width in bits; must be ≥ 2.
- STEP, 1: bits shifted per SHIFT cycle; power of two, 1..WIDTH.
- AMT_W, 8: width of the shift-amount input (ARM register form uses Rs[7:0]).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- data  in  WIDTH  operand to shift.
- shift  in  2  type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- amount  in  AMT_W  shift count.
- imm_form  in  1  1 = immediate-encoded amount (ARM #0 rules), 0 = register form.
- carry_in  in  1  current CPSR C.
- busy  out  1  high from the cycle after accept through the done cycle.
- done  out  1  one-cycle pulse; result and carry_out valid while high.
- result  out  WIDTH  shifted value; held until the next accept.
- carry_out  out  1  shifter carry; held until the next accept.

Behaviour:
- Reset (asynchronous, reset_n=0): FSM to IDLE; busy, done, carry_out = 0; result = 0; internal counter = 0. Reset mid-operation abandons the operation with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at cycle T captures data, shift, carry_in and the effective count N.
  - N=0 → DONE at T+1. Otherwise → SHIFT.
- SHIFT:
  - Each cycle shifts by min(STEP, remaining); remaining decrements by that amount.
  - carry_out tracks the last bit shifted out.
  - → DONE when remaining reaches 0.
  - Occupies T+1..T+ceil(N/STEP); done is high at T+ceil(N/STEP)+1.
- DONE: done=1 for exactly one cycle, then → IDLE. A start during DONE is ignored; a new start is accepted the cycle after.
- Input changes while busy are ignored (operands are captured at accept).
- Effective count N, register form:
  - amount=0: result=data, carry_out=carry_in.
  - LSL/LSR: N = min(amount, WIDTH+1). For amount=WIDTH, carry is the last bit out; for amount>WIDTH, result=0 and carry=0.
  - ASR: N = min(amount, WIDTH). Result fills with sign; carry = sign bit.
  - ROR: N = amount mod WIDTH. If that is 0 and amount≠0, N=WIDTH, giving result=data and carry_out=data[WIDTH-1].
- Effective count N, immediate form:
  - LSL #0: N=0 (passthrough with carry_in).
  - LSR #0 and ASR #0 mean shift by WIDTH.
  - ROR #0 is RRX: one SHIFT cycle, result={carry_in, data[WIDTH-1:1]}, carry_out=data[0].
  - Otherwise same as register form.
- Arithmetic rules: ASR replicates the captured data[WIDTH-1]. ROR rotate-out bit feeds the MSB. All operations are mod 2^WIDTH.
- Stability: result and carry_out are not guaranteed stable while busy=1 (they hold intermediate values). They are valid on done and held afterwards.

Optional Feature:
- Macro SHIFTER_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in SHIFT or DONE returns the FSM to IDLE on the next edge with no done pulse; result and carry_out keep their last values; abort in IDLE has no effect; abort has priority over completion in the same cycle.
- Undefined: no abort port; operations always run to done.

Test Plan:
- STEP=1, LSL, register form, data=0x8000_0001, amount=4, start at T → done at T+5, result=0x0000_0010, carry_out=0, busy high T+1..T+5.
- STEP=1, LSR, register form, data=0x8000_0000, amount=32 → done at T+33, result=0, carry_out=1. Then amount=40 → result=0, carry_out=0, done at T+34.
- STEP=4, ROR, register form, data=0x1234_5678, amount=8 → done at T+3, result=0x7812_3456, carry_out=0. Then amount=32 → result=0x1234_5678, carry_out=0 (data[31]=0).
- Immediate form, shift=11, amount=0, carry_in=1, data=0x0000_0003 → RRX: done at T+2, result=0x8000_0001, carry_out=1. Immediate ASR #0 with data=0x8000_0000 → result=0xFFFF_FFFF, carry_out=1.
- Register form, amount=0, LSL, carry_in=1, data=0xDEAD_BEEF → done at T+1, result=0xDEAD_BEEF, carry_out=1. Start held high through DONE → only one done pulse per accepted request.
- Reset asserted at T+3 of a 16-cycle LSR → busy/done/result/carry_out = 0 immediately, no done pulse. With SHIFTER_ABORT_EN defined, abort at T+3 → IDLE at T+4, no done pulse, the next start is accepted normally.

Source files
------------

// File: rtl/arm_seq_shifter.sv
// arm_seq_shifter: multi-cycle ARM operand-2 barrel shifter.
// Shifts STEP bits per cycle, with a start/done handshake toward the ALU.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               request, sampled only while idle
//   data, shift         operand and type (00 LSL, 01 LSR, 10 ASR, 11 ROR)
//   amount, imm_form    count and encoding (1 = immediate, #0 rules apply)
//   carry_in            current CPSR C
//   busy                high from the cycle after accept through the done cycle
//   done                one-cycle pulse; result/carry_out valid
//   result, carry_out   shifted value and shifter carry, held until next accept
//   abort               only with SHIFTER_ABORT_EN defined: drop the operation
//
// Optional feature macro: SHIFTER_ABORT_EN (adds the abort input).
module arm_seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef SHIFTER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       shift,
    input  logic [AMT_W-1:0] amount,
    input  logic             imm_form,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    // Counter must hold WIDTH+1 (LSL/LSR by more than WIDTH).
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int EW    = (AMT_W > CNT_W) ? AMT_W : CNT_W;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] work_q;
    logic             carry_q;
    logic [CNT_W-1:0] rem_q;
    logic [1:0]       op_q;
    logic             sign_q;
    logic             rrx_q;

    logic             abort_hit;

`ifdef SHIFTER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // ------------------------------------------------------------
    // Effective shift count at accept time
    // ------------------------------------------------------------
    logic [EW-1:0]    amt_x;
    logic [EW-1:0]    wide_w;
    logic [EW-1:0]    wide_w1;
    logic [EW-1:0]    ror_mod;
    logic [EW-1:0]    n_x;
    logic [CNT_W-1:0] n_eff;
    logic             rrx_sel;

    assign amt_x   = EW'(amount);
    assign wide_w  = EW'(WIDTH);
    assign wide_w1 = EW'(WIDTH + 1);
    assign ror_mod = amt_x % wide_w;

    always_comb begin
        n_x     = '0;
        rrx_sel = 1'b0;
        if (amount == '0) begin
            // Register form #0 and immediate LSL #0 are passthrough.
            if (imm_form) begin
                unique case (shift)
                    SH_LSL: n_x = '0;
                    SH_LSR: n_x = wide_w;
                    SH_ASR: n_x = wide_w;
                    SH_ROR: begin
                        n_x     = EW'(1);
                        rrx_sel = 1'b1;
                    end
                endcase
            end
        end else begin
            unique case (shift)
                SH_LSL: n_x = (amt_x > wide_w1) ? wide_w1 : amt_x;
                SH_LSR: n_x = (amt_x > wide_w1) ? wide_w1 : amt_x;
                SH_ASR: n_x = (amt_x > wide_w) ? wide_w : amt_x;
                // A nonzero multiple of WIDTH rotates all the way round
                // so the carry picks up data[WIDTH-1].
                SH_ROR: n_x = (ror_mod == '0) ? wide_w : ror_mod;
            endcase
        end
    end

    assign n_eff = CNT_W'(n_x);

    // ------------------------------------------------------------
    // One SHIFT cycle: up to STEP single-bit moves
    // ------------------------------------------------------------
    logic [WIDTH-1:0] nx_work;
    logic             nx_carry;
    logic             lsb;
    logic [CNT_W-1:0] step_now;
    logic             last_step;

    assign step_now  = (rem_q < CNT_W'(STEP)) ? rem_q : CNT_W'(STEP);
    assign last_step = (rem_q <= CNT_W'(STEP));

    always_comb begin
        nx_work  = work_q;
        nx_carry = carry_q;
        lsb      = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (CNT_W'(i) < rem_q) begin
                unique case (op_q)
                    SH_LSL: begin
                        nx_carry = nx_work[WIDTH-1];
                        nx_work  = {nx_work[WIDTH-2:0], 1'b0};
                    end
                    SH_LSR: begin
                        nx_carry = nx_work[0];
                        nx_work  = {1'b0, nx_work[WIDTH-1:1]};
                    end
                    SH_ASR: begin
                        nx_carry = nx_work[0];
                        nx_work  = {sign_q, nx_work[WIDTH-1:1]};
                    end
                    SH_ROR: begin
                        // RRX rotates through the carry instead.
                        lsb      = nx_work[0];
                        nx_work  = {rrx_q ? nx_carry : lsb,
                                    nx_work[WIDTH-1:1]};
                        nx_carry = lsb;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (n_eff == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over completion and suppresses the done pulse.
        if (abort_hit && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done    = 1'b0;
        end
    end

    // ------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work_q  <= '0;
            carry_q <= 1'b0;
            rem_q   <= '0;
            op_q    <= SH_LSL;
            sign_q  <= 1'b0;
            rrx_q   <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            work_q  <= data;
            carry_q <= carry_in;
            rem_q   <= n_eff;
            op_q    <= shift;
            sign_q  <= data[WIDTH-1];
            rrx_q   <= rrx_sel;
        end else if ((state_q == S_SHIFT) && !abort_hit) begin
            work_q  <= nx_work;
            carry_q <= nx_carry;
            rem_q   <= rem_q - step_now;
        end
    end

    assign result    = work_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_arm_seq_shifter.sv
// tb_arm_seq_shifter: scoreboard bench for arm_seq_shifter.
// Two instances: STEP=1 (u1) and STEP=4 (u2), WIDTH=32.
module tb_arm_seq_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        s1_start, s2_start;
    logic [31:0] s1_data, s2_data;
    logic [1:0]  s1_shift, s2_shift;
    logic [7:0]  s1_amt, s2_amt;
    logic        s1_imm, s2_imm;
    logic        s1_cin, s2_cin;
    logic        busy1, busy2, done1, done2, c1, c2;
    logic [31:0] res1, res2;
`ifdef SHIFTER_ABORT_EN
    logic        abort1, abort2;
`endif

    arm_seq_shifter #(.WIDTH(32), .STEP(1), .AMT_W(8)) u1 (
        .clk(clk), .reset_n(reset_n),
`ifdef SHIFTER_ABORT_EN
        .abort(abort1),
`endif
        .start(s1_start), .data(s1_data), .shift(s1_shift),
        .amount(s1_amt), .imm_form(s1_imm), .carry_in(s1_cin),
        .busy(busy1), .done(done1), .result(res1), .carry_out(c1)
    );

    arm_seq_shifter #(.WIDTH(32), .STEP(4), .AMT_W(8)) u2 (
        .clk(clk), .reset_n(reset_n),
`ifdef SHIFTER_ABORT_EN
        .abort(abort2),
`endif
        .start(s2_start), .data(s2_data), .shift(s2_shift),
        .amount(s2_amt), .imm_form(s2_imm), .carry_in(s2_cin),
        .busy(busy2), .done(done2), .result(res2), .carry_out(c2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          t;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL u1 unexpected done: got res=%h want none",
                         res1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("u1 result", res1, e.res);
                chk("u1 carry", {31'b0, c1}, {31'b0, e.c});
                chk("u1 latency", 32'(cyc - e.t), 32'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL u2 unexpected done: got res=%h want none",
                         res2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("u2 result", res2, e.res);
                chk("u2 carry", {31'b0, c2}, {31'b0, e.c});
                chk("u2 latency", 32'(cyc - e.t), 32'(e.lat));
            end
        end
    end

    function automatic int qsize(input int d);
        return (d == 1) ? q1.size() : q2.size();
    endfunction

    function automatic logic busy_of(input int d);
        return (d == 1) ? busy1 : busy2;
    endfunction

    function automatic logic done_of(input int d);
        return (d == 1) ? done1 : done2;
    endfunction

    task automatic drive(input int d, input logic st, input logic [31:0] dt,
                         input logic [1:0] sh, input logic [7:0] am,
                         input logic im, input logic ci);
        if (d == 1) begin
            s1_start = st; s1_data = dt; s1_shift = sh;
            s1_amt = am; s1_imm = im; s1_cin = ci;
        end else begin
            s2_start = st; s2_data = dt; s2_shift = sh;
            s2_amt = am; s2_imm = im; s2_cin = ci;
        end
    endtask

    // Issue one request; hold = cycles start stays high.
    task automatic issue(input int d, input logic [31:0] dt,
                         input logic [1:0] sh, input logic [7:0] am,
                         input logic im, input logic ci,
                         input logic [31:0] er, input logic ec,
                         input int lat, input int hold);
        exp_t e;
        @(negedge clk); #1;
        e.res = er; e.c = ec; e.t = cyc; e.lat = lat;
        if (d == 1) q1.push_back(e);
        else q2.push_back(e);
        drive(d, 1'b1, dt, sh, am, im, ci);
        @(negedge clk); #1;
        chk((d == 1) ? "u1 busy after accept" : "u2 busy after accept",
            {31'b0, busy_of(d)}, 32'd1);
        if (hold > 1) begin
            @(negedge clk); #1;
        end
        // Scramble operands: they must already be captured.
        drive(d, 1'b0, ~dt, ~sh, ~am, ~im, ~ci);
        for (int k = 0; k < 200 && qsize(d) != 0; k++) begin
            @(negedge clk); #1;
        end
        if (qsize(d) != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL u%0d timeout: got no done want done", d);
            if (d == 1) q1.delete();
            else q2.delete();
        end
        @(negedge clk); #1;
        chk((d == 1) ? "u1 idle busy" : "u2 idle busy",
            {31'b0, busy_of(d)}, 32'd0);
        chk((d == 1) ? "u1 idle done" : "u2 idle done",
            {31'b0, done_of(d)}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1, 1'b0, '0, 2'b00, '0, 1'b0, 1'b0);
        drive(2, 1'b0, '0, 2'b00, '0, 1'b0, 1'b0);
`ifdef SHIFTER_ABORT_EN
        abort1 = 1'b0;
        abort2 = 1'b0;
`endif
        #12;
        chk("reset busy1", {31'b0, busy1}, 32'd0);
        chk("reset done1", {31'b0, done1}, 32'd0);
        chk("reset result1", res1, 32'd0);
        chk("reset carry1", {31'b0, c1}, 32'd0);
        chk("reset busy2", {31'b0, busy2}, 32'd0);
        chk("reset result2", res2, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // u1, STEP=1: dut, data, shift, amt, imm, cin, res, c, lat, hold
        issue(1, 32'h8000_0001, 2'b00, 8'd4, 1'b0, 1'b0,
              32'h0000_0010, 1'b0, 5, 1);
        issue(1, 32'h8000_0000, 2'b01, 8'd32, 1'b0, 1'b0,
              32'h0000_0000, 1'b1, 33, 1);
        issue(1, 32'h8000_0000, 2'b01, 8'd40, 1'b0, 1'b0,
              32'h0000_0000, 1'b0, 34, 1);
        issue(1, 32'h0000_0003, 2'b11, 8'd0, 1'b1, 1'b1,
              32'h8000_0001, 1'b1, 2, 1);
        issue(1, 32'h8000_0000, 2'b10, 8'd0, 1'b1, 1'b0,
              32'hFFFF_FFFF, 1'b1, 33, 1);
        issue(1, 32'hDEAD_BEEF, 2'b00, 8'd0, 1'b0, 1'b1,
              32'hDEAD_BEEF, 1'b1, 1, 2);
        issue(1, 32'h0000_1234, 2'b00, 8'd0, 1'b1, 1'b0,
              32'h0000_1234, 1'b0, 1, 1);
        issue(1, 32'h8000_0000, 2'b01, 8'd0, 1'b1, 1'b0,
              32'h0000_0000, 1'b1, 33, 1);
        issue(1, 32'h8000_00F8, 2'b10, 8'd4, 1'b0, 1'b0,
              32'hF800_000F, 1'b1, 5, 1);
        issue(1, 32'h4000_0000, 2'b10, 8'd200, 1'b0, 1'b1,
              32'h0000_0000, 1'b0, 33, 1);
        issue(1, 32'hFFFF_FFFF, 2'b00, 8'd33, 1'b0, 1'b1,
              32'h0000_0000, 1'b0, 34, 1);
        issue(1, 32'h0000_0001, 2'b00, 8'd32, 1'b0, 1'b0,
              32'h0000_0000, 1'b1, 33, 1);
        issue(1, 32'h0000_000F, 2'b11, 8'd4, 1'b0, 1'b0,
              32'hF000_0000, 1'b1, 5, 1);

        // u2, STEP=4
        issue(2, 32'h1234_5678, 2'b11, 8'd8, 1'b0, 1'b1,
              32'h7812_3456, 1'b0, 3, 1);
        issue(2, 32'h1234_5678, 2'b11, 8'd32, 1'b0, 1'b1,
              32'h1234_5678, 1'b0, 9, 1);
        issue(2, 32'h0800_0001, 2'b00, 8'd5, 1'b0, 1'b0,
              32'h0000_0020, 1'b1, 3, 1);
        issue(2, 32'hFFFF_FFFF, 2'b01, 8'd33, 1'b0, 1'b1,
              32'h0000_0000, 1'b0, 10, 1);
        issue(2, 32'h8000_0040, 2'b10, 8'd7, 1'b0, 1'b0,
              32'hFF00_0000, 1'b1, 3, 1);
        issue(2, 32'h8000_0000, 2'b11, 8'd0, 1'b1, 1'b0,
              32'h4000_0000, 1'b0, 2, 1);
        issue(2, 32'h0000_000F, 2'b11, 8'd36, 1'b0, 1'b0,
              32'hF000_0000, 1'b1, 2, 1);

        // Reset during a 16-cycle LSR on u1: no done may follow.
        @(negedge clk); #1;
        drive(1, 1'b1, 32'hFFFF_FFFF, 2'b01, 8'd16, 1'b0, 1'b0);
        @(negedge clk); #1;
        s1_start = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midreset busy1", {31'b0, busy1}, 32'd0);
        chk("midreset done1", {31'b0, done1}, 32'd0);
        chk("midreset result1", res1, 32'd0);
        chk("midreset carry1", {31'b0, c1}, 32'd0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        #1;
        chk("post-reset busy1", {31'b0, busy1}, 32'd0);

`ifdef SHIFTER_ABORT_EN
        // Abort at T+3: idle at T+4, values frozen, no done pulse.
        @(negedge clk); #1;
        drive(1, 1'b1, 32'hFFFF_FFFF, 2'b01, 8'd16, 1'b0, 1'b0);
        @(negedge clk); #1;
        s1_start = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        abort1 = 1'b1;
        @(negedge clk); #1;
        abort1 = 1'b0;
        chk("abort busy1", {31'b0, busy1}, 32'd0);
        chk("abort result1", res1, 32'h3FFF_FFFF);
        chk("abort carry1", {31'b0, c1}, 32'd1);
        repeat (20) @(negedge clk);
        issue(1, 32'h0000_00F0, 2'b01, 8'd4, 1'b0, 1'b0,
              32'h0000_000F, 1'b0, 5, 1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
